comparator_iter: RTL
====================

Name: comparator_iter

Overview:
- Multi-cycle, parametrised successor to the combinational comparator_eq/comparator_lt pair.
- Compares two N-bit operands SLICE bits per cycle, MSB slice first.
- Evaluates all six RISC-V branch conditions (signed and unsigned) and returns a result over a valid/ready handshake.
- Sits beside the ALU as the branch-condition unit for area-constrained builds.

Parameters:
- N, 32, operand width; must be a multiple of SLICE (elaboration-time $fatal otherwise).
- SLICE, 8, bits compared per cycle; NSL = N/SLICE slices; 1 <= SLICE <= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_a  input  N  operand a, two's complement or unsigned per op.
- in_b  input  N  operand b.
- in_op  input  3  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010 and 011 illegal.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- out_result  output  1  branch condition true.
- out_eq  output  1  a == b.
- out_lt  output  1  a < b, signed for 10x ops, unsigned for 11x ops, 0 for EQ/NE/illegal.
- out_illegal  output  1  in_op was 010 or 011.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_eq=0, out_lt=0, out_illegal=0, slice index=0.
- An in-flight request is dropped on reset; it produces no output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, register a, b, op; set idx=NSL-1.
  - Go to SCAN, or to DONE directly if op is illegal.
- SCAN (in_ready=0), each cycle compares slice idx of a and b:
  - Signed ops: on the top slice, invert the MSB of both slices before an unsigned compare. All other slices compare unsigned.
  - Slices differ: latch eq=0 and lt=(slice_a<slice_b). Go to DONE if COMPARATOR_EARLY_EXIT_EN is defined; otherwise freeze the verdict and continue scanning.
  - Slices equal and idx==0: if no difference was latched, eq=1 and lt=0. Go to DONE.
  - Otherwise idx decrements. idx never wraps below 0.
- DONE:
  - out_valid=1; out_* are stable while out_valid && !out_ready.
  - out_result by op: EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt.
  - Illegal op: out_result=0, out_eq=0, out_lt=0, out_illegal=1.
  - On out_ready at an edge: out_valid=0, go to IDLE. The next request is accepted no earlier than the following edge, so there is no back-to-back bypass.
- Latency (accept edge to out_valid rising):
  - Full scan: NSL edges.
  - Illegal op: 1 edge.
  - Early exit (macro defined): s edges, where s is the 1-based step of the first differing slice counted from the MSB.
- Only the first differing slice determines lt; later slices never overwrite it.
- in_a, in_b and in_op are ignored outside the accept edge.
- SLICE==N degenerates to a single SCAN cycle.

Optional Feature:
- COMPARATOR_EARLY_EXIT_EN defined: SCAN terminates at the first differing slice, giving data-dependent latency of 1..NSL.
- Undefined: latency is always NSL cycles for legal ops (constant-time, timing-side-channel free); results are identical either way.

Test Plan:
- Reset mid-SCAN: N=32, SLICE=8, accept a=5, b=5, op=EQ, pull rst_n low 2 cycles later -> out_valid=0 and in_ready=1 immediately (asynchronous), no result is ever emitted; next request completes normally.
- Signed vs unsigned: a=32'hFFFF_FFFF, b=1; op=LT -> result=1, lt=1; op=LTU -> result=0, lt=0; op=GEU -> result=1.
- Equality, full scan: a=b=32'h1234_5678, op=EQ -> eq=1, result=1, out_valid 4 edges after accept (both macro settings); op=NE -> result=0.
- Early exit: a=32'h0100_0000, b=32'h0000_0000, op=GE -> result=1, lt=0; out_valid 1 edge after accept with the macro, 4 edges without. a=32'h0000_0001 vs b=0 -> 4 edges in both builds.
- Backpressure and illegal op: op=3'b010 -> out_valid 1 edge after accept, illegal=1, result=0. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; after out_ready, in_ready returns the next cycle.
- Random sweep: 1000 random pairs plus 1000 forced a==b pairs across all six ops, N=32/SLICE=8 and N=16/SLICE=16 -> every result matches the golden SystemVerilog signed/unsigned ==, < and >=.

Source files
------------

// File: rtl/comparator_iter_if.sv
// Request/response bundle for the iterative branch-condition comparator.
// master drives requests and accepts results; slave is the comparator side.
interface comparator_iter_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic         out_result;
  logic         out_eq;
  logic         out_lt;
  logic         out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_eq, out_lt, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_eq, out_lt, out_illegal
  );
endinterface

// File: rtl/comparator_iter.sv
// Multi-cycle RISC-V branch-condition comparator, SLICE bits per cycle, MSB slice first.
// Define COMPARATOR_EARLY_EXIT_EN to stop scanning at the first differing slice.
module comparator_iter #(
  parameter int unsigned N     = 32,
  parameter int unsigned SLICE = 8
) (
  input logic         clk,
  input logic         rst_n,
  comparator_iter_if.slave bus
);
  localparam int unsigned SafeSlice = (SLICE == 0) ? 1 : SLICE;
  localparam int unsigned NSL       = N / SafeSlice;
  localparam int unsigned IdxW      = (NSL > 1) ? $clog2(NSL) : 1;

  if ((SLICE == 0) || (SLICE > N) || ((N % SafeSlice) != 0)) begin : g_bad_cfg
    $fatal(1, "comparator_iter: N must be a non-zero multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [2:0]      op_q;
  logic [IdxW-1:0] idx_q;
  logic            diff_q, eq_q, lt_q;
  logic            in_ready_q, out_valid_q, out_result_q, out_eq_q, out_lt_q, out_illegal_q;

  logic [N-1:0]     a_sh, b_sh;
  logic [SLICE-1:0] sa, sb;
  logic             last, finish, diff_nxt, eq_nxt, lt_nxt, res_nxt, lt_out_nxt;

  always_comb begin
    a_sh = a_q >> (32'(idx_q) * SLICE);
    b_sh = b_q >> (32'(idx_q) * SLICE);
    sa   = a_sh[SLICE-1:0];
    sb   = b_sh[SLICE-1:0];
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (op_q[2] && !op_q[1] && (idx_q == IdxW'(NSL - 1))) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
    last     = (idx_q == '0);
    finish   = last;
    diff_nxt = diff_q;
    eq_nxt   = eq_q;
    lt_nxt   = lt_q;
    if (sa != sb) begin
      if (!diff_q) begin
        diff_nxt = 1'b1;
        eq_nxt   = 1'b0;
        lt_nxt   = (sa < sb);
      end
`ifdef COMPARATOR_EARLY_EXIT_EN
      finish = 1'b1;
`endif
    end else if (last && !diff_q) begin
      eq_nxt = 1'b1;
      lt_nxt = 1'b0;
    end
    res_nxt    = op_q[2] ? (lt_nxt ^ op_q[0]) : (eq_nxt ^ op_q[0]);
    lt_out_nxt = op_q[2] & lt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      idx_q         <= '0;
      diff_q        <= 1'b0;
      eq_q          <= 1'b0;
      lt_q          <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_result_q  <= 1'b0;
      out_eq_q      <= 1'b0;
      out_lt_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            op_q       <= bus.in_op;
            idx_q      <= IdxW'(NSL - 1);
            diff_q     <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= (bus.in_op[2:1] == 2'b01) ? StDone : StScan;
          end
        end
        StScan: begin
          diff_q <= diff_nxt;
          eq_q   <= eq_nxt;
          lt_q   <= lt_nxt;
          if (finish) begin
            state_q       <= StDone;
            out_valid_q   <= 1'b1;
            out_result_q  <= res_nxt;
            out_eq_q      <= eq_nxt;
            out_lt_q      <= lt_out_nxt;
            out_illegal_q <= 1'b0;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          // Illegal ops arrive here with out_valid low and raise it one edge later.
          if (!out_valid_q) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= 1'b0;
            out_eq_q      <= 1'b0;
            out_lt_q      <= 1'b0;
            out_illegal_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= 1'b0;
            out_eq_q      <= 1'b0;
            out_lt_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            in_ready_q    <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_eq      = out_eq_q;
  assign bus.out_lt      = out_lt_q;
  assign bus.out_illegal = out_illegal_q;
endmodule
